// File: rtl/axi4_lite_master_ctrl_if.sv
// AXI4-Lite bus bundle between the command-driven initiator and a register-map slave.
// Only the five AXI channels live here; clock and reset stay plain ports.
interface axi4_lite_master_ctrl_if #(
    parameter int ADDR_WIDTH = 13
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4_lite_master_ctrl.sv
// AXI4-Lite initiator: one local command at a time becomes a single AXI read or write,
// with the response, echoed direction and AXI-side cycle count returned on the rsp port.
module axi4_lite_master_ctrl #(
    parameter int ADDR_WIDTH = 13,
    parameter int LAT_WIDTH  = 8
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_we,
    output logic [LAT_WIDTH-1:0]  rsp_latency,
    axi4_lite_master_ctrl_if.master m_axi
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0]           wdata_r;
    logic [3:0]            wstrb_r;
    logic                  aw_done, w_done;
    logic                  accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs, busy;

    function automatic logic [LAT_WIDTH-1:0] sat_inc(input logic [LAT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept = cmd_valid & cmd_ready;
    assign aw_hs  = m_axi.awvalid & m_axi.awready;
    assign w_hs   = m_axi.wvalid & m_axi.wready;
    assign b_hs   = m_axi.bvalid & m_axi.bready;
    assign ar_hs  = m_axi.arvalid & m_axi.arready;
    assign r_hs   = m_axi.rvalid & m_axi.rready;
    assign rsp_hs = rsp_valid & rsp_ready;
    assign busy   = (state == WR_REQ) || (state == WR_RESP) || (state == RD_REQ) || (state == RD_DATA);

    assign m_axi.awaddr = addr_r;
    assign m_axi.araddr = addr_r;
    assign m_axi.wdata  = wdata_r;
    assign m_axi.wstrb  = wstrb_r;
    assign m_axi.awprot = 3'b000;
    assign m_axi.arprot = 3'b000;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = cmd_we ? WR_REQ : RD_REQ;
            // AW and W may complete in either order or together
            WR_REQ:  if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = WR_RESP;
            WR_RESP: if (b_hs) state_nxt = RSP;
            RD_REQ:  if (ar_hs) state_nxt = RD_DATA;
            RD_DATA: if (r_hs) state_nxt = RSP;
            RSP:     if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = 1'b0;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;
        m_axi.arvalid = 1'b0;
        m_axi.rready  = 1'b0;
        rsp_valid     = 1'b0;
        case (state)
            IDLE:    cmd_ready = 1'b1;
            WR_REQ: begin
                m_axi.awvalid = !aw_done;
                m_axi.wvalid  = !w_done;
            end
            WR_RESP: m_axi.bready  = 1'b1;
            RD_REQ:  m_axi.arvalid = 1'b1;
            RD_DATA: m_axi.rready  = 1'b1;
            RSP:     rsp_valid     = 1'b1;
            default: ;
        endcase
    end

    // Request capture, per-channel completion flags and response capture
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            addr_r      <= '0;
            wdata_r     <= '0;
            wstrb_r     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_we      <= 1'b0;
            rsp_latency <= '0;
        end else begin
            if (accept) begin
                addr_r      <= cmd_addr;
                wdata_r     <= cmd_wdata;
                wstrb_r     <= cmd_wstrb;
                rsp_we      <= cmd_we;
                aw_done     <= 1'b0;
                w_done      <= 1'b0;
                rsp_latency <= '0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (busy)  rsp_latency <= sat_inc(rsp_latency);
            if (b_hs) begin
                rsp_rdata <= '0;
                rsp_resp  <= m_axi.bresp;
            end
            if (r_hs) begin
                rsp_rdata <= m_axi.rdata;
                rsp_resp  <= m_axi.rresp;
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_master_ctrl.sv
// Bench for axi4_lite_master_ctrl: a transaction-schedule model predicts every output per cycle
// from the slave delays chosen by the bench; a negedge process compares the DUT against it.
module tb_axi4_lite_master_ctrl;
    localparam int AW  = 13;
    localparam int LW  = 8;
    localparam int LMAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_we;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [LW-1:0] rsp_latency;

    always #5 clk = ~clk;

    axi4_lite_master_ctrl_if #(.ADDR_WIDTH(AW)) axi ();

    axi4_lite_master_ctrl #(.ADDR_WIDTH(AW), .LAT_WIDTH(LW)) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_we(rsp_we), .rsp_latency(rsp_latency),
        .m_axi(axi)
    );

    int checks = 0, failures = 0;
    logic chk_en = 1'b0;

    logic          exp_cmd_ready, exp_awvalid, exp_wvalid, exp_bready, exp_arvalid, exp_rready, exp_rsp_valid;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_wdata, exp_rdata;
    logic [3:0]    exp_wstrb;
    logic [1:0]    exp_resp;
    logic          exp_we;
    logic [LW-1:0] exp_lat;

    logic [31:0]   mem [logic [AW-1:0]];
    logic [LW-1:0] last_lat;
    logic [31:0]   last_rdata;
    logic [1:0]    last_resp;
    int            first_rsp_off;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle_exp();
        exp_cmd_ready = 1'b1;
        exp_awvalid = 1'b0; exp_wvalid = 1'b0; exp_bready = 1'b0;
        exp_arvalid = 1'b0; exp_rready = 1'b0; exp_rsp_valid = 1'b0;
    endtask

    task automatic quiet_inputs();
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", cmd_ready, exp_cmd_ready);
            chk("awvalid", axi.awvalid, exp_awvalid);
            chk("wvalid", axi.wvalid, exp_wvalid);
            chk("bready", axi.bready, exp_bready);
            chk("arvalid", axi.arvalid, exp_arvalid);
            chk("rready", axi.rready, exp_rready);
            chk("rsp_valid", rsp_valid, exp_rsp_valid);
            chk("prot", {axi.awprot, axi.arprot}, 6'd0);
            if (exp_awvalid) chk("awaddr", axi.awaddr, exp_addr);
            if (exp_arvalid) chk("araddr", axi.araddr, exp_addr);
            if (exp_wvalid) begin
                chk("wdata", axi.wdata, exp_wdata);
                chk("wstrb", axi.wstrb, exp_wstrb);
            end
            if (exp_rsp_valid) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_resp", rsp_resp, exp_resp);
                chk("rsp_we", rsp_we, exp_we);
                chk("rsp_latency", rsp_latency, exp_lat);
            end
        end
    end

    // One whole transaction from accept (offset 0) to the rsp handshake.
    // Write: d1 = AW delay, d2 = W delay, bd = B delay. Read: d1 = AR delay, d2 = R delay.
    // noise: 0 = cmd_valid low while busy, 1 = random junk, 2 = held high.
    task automatic run_txn(input bit we, input logic [AW-1:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int d1, input int d2, input int bd,
                           input int rsp_d, input logic [1:0] resp, input int noise);
        int hs_done, last, end_off;
        logic [31:0] rd_val, merged;
        hs_done = 1 + ((d1 > d2) ? d1 : d2);
        last    = we ? hs_done + 1 + bd : 1 + d1 + 1 + d2;
        end_off = last + 1 + rsp_d;
        rd_val  = mem.exists(addr) ? mem[addr] : $urandom;
        if (!we) mem[addr] = rd_val;
        first_rsp_off = -1;
        exp_addr = addr; exp_wdata = wd; exp_wstrb = ws; exp_we = we; exp_resp = resp;
        exp_rdata = we ? 32'd0 : rd_val;
        exp_lat = LW'((last > LMAX) ? LMAX : last);
        for (int c = 0; c <= end_off; c++) begin
            if (c == 0) begin
                cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
            end else begin
                cmd_valid = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                cmd_we = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
            end
            rsp_ready   = (c == end_off) || (noise != 0 && c <= last && $urandom_range(0, 1) == 1);
            axi.awready = we && (c == 1 + d1);
            axi.wready  = we && (c == 1 + d2);
            axi.bvalid  = we && (c == last);
            axi.bresp   = (c == last) ? resp : 2'($urandom);
            axi.arready = !we && (c == 1 + d1);
            axi.rvalid  = !we && (c == last);
            axi.rdata   = (c == last) ? rd_val : $urandom;
            axi.rresp   = (c == last) ? resp : 2'($urandom);
            exp_cmd_ready = (c == 0);
            exp_awvalid   = we && c >= 1 && c <= 1 + d1;
            exp_wvalid    = we && c >= 1 && c <= 1 + d2;
            exp_bready    = we && c >= hs_done + 1 && c <= last;
            exp_arvalid   = !we && c >= 1 && c <= 1 + d1;
            exp_rready    = !we && c >= 2 + d1 && c <= last;
            exp_rsp_valid = (c > last);
            if (rsp_valid && first_rsp_off < 0) first_rsp_off = c;
            if (c == end_off) begin
                last_lat = rsp_latency; last_rdata = rsp_rdata; last_resp = rsp_resp;
            end
            step();
        end
        if (we) begin
            merged = mem.exists(addr) ? mem[addr] : 32'd0;
            for (int b = 0; b < 4; b++) if (ws[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
            mem[addr] = merged;
        end
        quiet_inputs();
        set_idle_exp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            quiet_inputs();
            set_idle_exp();
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        quiet_inputs();
        set_idle_exp();
        rst_n = 1'b0;
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid}, 6'd0);
        chk("rst_awaddr", axi.awaddr, '0);
        chk("rst_wdata", {axi.wdata, axi.wstrb}, '0);
        chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_we, rsp_latency}, '0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        run_txn(1'b1, 13'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 0);
        chk("t1_latency", last_lat, 8'd2);
        chk("t1_rsp_offset", first_rsp_off, 3);
        idle(1);

        mem[13'h004] = 32'h12345678;
        run_txn(1'b0, 13'h004, 32'h0, 4'h0, 2, 3, 0, 0, 2'b00, 0);
        chk("t2_latency", last_lat, 8'd7);
        chk("t2_rdata", last_rdata, 32'h12345678);
        chk("t2_rsp_offset", first_rsp_off, 8);
        idle(1);

        run_txn(1'b1, 13'h020, 32'hA5A55A5A, 4'h5, 4, 1, 0, 0, 2'b00, 0);
        chk("t3_latency", last_lat, 8'd6);
        idle(2);

        run_txn(1'b0, 13'h030, 32'h0, 4'h0, 0, 0, 0, 4, 2'b10, 0);
        chk("t4_resp", last_resp, 2'b10);
        chk("t4_latency", last_lat, 8'd2);

        run_txn(1'b0, 13'h004, 32'h0, 4'h0, 1, 1, 0, 1, 2'b00, 2);
        run_txn(1'b1, 13'h004, 32'hCAFEF00D, 4'h3, 0, 2, 1, 0, 2'b11, 2);
        run_txn(1'b0, 13'h004, 32'h0, 4'h0, 0, 0, 0, 0, 2'b01, 0);
        chk("t5_merged_rdata", last_rdata, 32'h1234F00D);
        idle(1);

        // Reset pulsed while the read waits in the data phase
        chk_en = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 13'h040;
        step();
        cmd_valid = 1'b0; axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        step();
        chk("t6_rready_before", axi.rready, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_valids_in_reset", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid}, 6'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t6_cmd_ready_after", cmd_ready, 1'b1);
        set_idle_exp();
        chk_en = 1'b1;
        step();
        run_txn(1'b0, 13'h040, 32'h0, 4'h0, 1, 2, 0, 1, 2'b00, 0);
        chk("t6_next_latency", last_lat, 8'd5);
        idle(1);

        run_txn(1'b0, 13'h050, 32'h0, 4'h0, 0, 300, 0, 0, 2'b00, 0);
        chk("sat_latency", last_lat, 8'd255);

        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15) * 4), $urandom, 4'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                    $urandom_range(0, 4), 2'($urandom_range(0, 3)), 1);
            idle($urandom_range(0, 2));
        end

        idle(2);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
